smc_stream_eval: RTL and testbench
==================================

Name: smc_stream_eval

Overview:
- Sequential, parametrised successor to the combinational six-MOSFET current/transconductance evaluator.
- Accepts N_DEV transistor descriptors serially under an in_valid handshake and computes each device's Id or gm (Vth = 1).
- Keeps the devices sorted on the fly by insertion sort, then emits one weighted average of the K_SEL largest or smallest values.
- Sits between the pattern-driven input stage and the result checker.

Parameters:
- N_DEV, 6, devices per burst (K_SEL <= N_DEV <= 16).
- IN_W, 3, width of w, v_gs, v_ds (unsigned).
- K_SEL, 3, number of sorted values combined into the result.
- OUT_W, 10, width of out_n.
- VAL_W (localparam), derived, per-device value width; sized for the maximum Id with W, V_GS and V_DS all at 2^IN_W-1 (7 bits at default).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  descriptor valid; high for N_DEV consecutive cycles per burst.
- mode  in  2  sampled on the first in_valid cycle only. Bit 0: 1 = Id, 0 = gm. Bit 1: 1 = largest K_SEL, 0 = smallest K_SEL.
- w  in  IN_W  device width.
- v_gs  in  IN_W  gate-source voltage.
- v_ds  in  IN_W  drain-source voltage.
- out_valid  out  1  result strobe, one cycle.
- out_n  out  OUT_W  result; 0 whenever out_valid is low.

Behaviour:
- Reset: out_valid=0, out_n=0, FSM=IDLE, sample counter=0, sorted array cleared to 0. Reset asserted mid-burst or mid-calc aborts the operation with no output.
- FSM states IDLE, LOAD, CALC, OUT:
  - IDLE -> LOAD on in_valid.
  - LOAD -> CALC after the N_DEV-th sample.
  - CALC -> OUT after 1 cycle.
  - OUT -> IDLE after 1 cycle.
- Per-device value. Let ov = v_gs - 1, computed signed.
  - Cutoff (v_gs <= 1): value = 0.
  - Triode (ov > v_ds): Id = floor(w*(2*ov*v_ds - v_ds^2)/3), gm = floor(2*w*v_ds/3).
  - Saturation (otherwise): Id = floor(w*ov^2/3), gm = floor(2*w*ov/3).
- Sort:
  - Each accepted sample is inserted the same cycle into the descending array d[0..N_DEV-1].
  - Equal values: the new value goes after existing equal entries.
  - The counter wraps to 0 after N_DEV.
- Selection: a_i = d[i] when mode[1]=1; a_i = d[N_DEV-K_SEL+i] when mode[1]=0; i = 0..K_SEL-1.
- Result:
  - gm mode: floor(sum a_i / K_SEL).
  - Id mode: floor(sum (K_SEL+i)*a_i / D), where D = sum of the weights (12 at K_SEL=3).
  - Full-precision intermediates; the result is truncated to OUT_W.
- Latency: last sample accepted at edge t; registered result at edge t+1 (CALC); out_valid=1 for exactly one cycle from edge t+2.
- Boundary conditions:
  - in_valid dropping mid-burst: discard the burst, return to IDLE, no out_valid.
  - in_valid asserted during CALC or OUT: ignored, no sample accepted.
  - A new burst may start the cycle after OUT.
  - The sorted array is cleared on entering LOAD.

Optional Feature:
- Macro SMC_REGION_CNT_EN.
- When defined, adds output sat_cnt [$clog2(N_DEV+1)-1:0]: the count of saturation-region devices in the burst.
  - Valid with out_valid; 0 otherwise; reset 0.
- When undefined, the port and its logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset then mode=3, six devices (7,7,7) -> out_n=84 at t+2, out_valid high 1 cycle.
- mode=3, devices (7,7,7),(1,3,1),(3,4,7),(2,3,1),(7,7,2),(1,1,5) -> sorted 84,46,9,2,1,0; out_n=40. Same burst with mode=1 -> out_n=0.
- mode=2, six (7,7,7) -> out_n=28; with SMC_REGION_CNT_EN, sat_cnt=6.
- in_valid low after 4 samples -> no out_valid. Next full burst of six (7,7,7), mode=3 -> out_n=84.
- rst_n pulsed low during CALC -> out_valid stays 0, out_n=0, FSM in IDLE; next burst correct.
- Back-to-back bursts starting the cycle after OUT, random 2000 bursts vs. C model -> all match.

Source files
------------

// File: rtl/smc_stream_eval.sv
// smc_stream_eval
//   Streaming MOSFET evaluator. A burst of N_DEV transistor descriptors
//   arrives on consecutive in_valid cycles. Each descriptor is turned into
//   Id or gm, using a threshold voltage of 1. The value is insertion-sorted
//   into a descending array in the same cycle it arrives. After the last
//   sample the K_SEL largest (or smallest) values are combined into one
//   weighted average. That average is presented for a single cycle.
//
// Optional feature (macro SMC_REGION_CNT_EN):
//   Adds output sat_cnt, which counts the saturation-region devices in the
//   burst. It is valid together with out_valid and is 0 otherwise.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      descriptor valid, N_DEV consecutive cycles per burst
//   mode       in   2      sampled on the first sample of a burst only
//                          bit0: 1 = Id, 0 = gm
//                          bit1: 1 = largest K_SEL, 0 = smallest K_SEL
//   w          in   IN_W   device width
//   v_gs       in   IN_W   gate-source voltage
//   v_ds       in   IN_W   drain-source voltage
//   out_valid  out  1      one-cycle result strobe
//   out_n      out  OUT_W  result, 0 while out_valid is low
//   sat_cnt    out  clog2(N_DEV+1)  saturation count (SMC_REGION_CNT_EN only)
module smc_stream_eval #(
  parameter int N_DEV = 6,
  parameter int IN_W  = 3,
  parameter int K_SEL = 3,
  parameter int OUT_W = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [1:0]                     mode,
  input  logic [IN_W-1:0]                w,
  input  logic [IN_W-1:0]                v_gs,
  input  logic [IN_W-1:0]                v_ds,
  output logic                           out_valid,
  output logic [OUT_W-1:0]               out_n
`ifdef SMC_REGION_CNT_EN
  ,
  output logic [$clog2(N_DEV+1)-1:0]     sat_cnt
`endif
);

  localparam int CNT_W   = $clog2(N_DEV + 1);
  localparam int MAX_IN  = (1 << IN_W) - 1;
  // Saturation with every input at full scale is the largest value possible.
  // Triode current is bounded by the saturation current at the same ov.
  localparam int MAX_ID  = MAX_IN * (MAX_IN - 1) * (MAX_IN - 1) / 3;
  localparam int MAX_GM  = 2 * MAX_IN * (MAX_IN - 1) / 3;
  localparam int MAX_VAL = (MAX_ID > MAX_GM) ? MAX_ID : MAX_GM;
  localparam int VAL_W   = (MAX_VAL > 0) ? $clog2(MAX_VAL + 1) : 1;
  localparam int PROD_W  = 3 * IN_W + 2;
  // Id weights run K_SEL .. 2*K_SEL-1, and D_ID is their sum.
  localparam int D_ID    = K_SEL * K_SEL + K_SEL * (K_SEL - 1) / 2;
  localparam int SUM_W   = VAL_W + $clog2(D_ID + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         mode_reg;
  logic [VAL_W-1:0]   d_reg [N_DEV];
  logic [OUT_W-1:0]   result_reg;
  logic               out_valid_next;
  logic [OUT_W-1:0]   out_n_next;

  logic first, accept, last_sample, eff_id;

  assign first       = (state_reg == S_IDLE);
  assign accept      = in_valid && (state_reg == S_IDLE || state_reg == S_LOAD);
  assign last_sample = first ? (N_DEV == 1) : (cnt_reg == CNT_W'(N_DEV - 1));
  // mode is live on the first sample and is held in mode_reg afterwards.
  assign eff_id      = first ? mode[0] : mode_reg[0];

  // ---------------- per-device value ----------------
  logic [IN_W-1:0]   ov;
  logic              is_cut, is_tri;
  logic [PROD_W-1:0] w_e, ov_e, vds_e, prod;
  logic [VAL_W-1:0]  new_val;

  // ov is only meaningful when v_gs >= 2, so it never goes negative there.
  assign ov     = v_gs - 1'b1;
  assign is_cut = (v_gs <= IN_W'(1));
  assign is_tri = !is_cut && (ov > v_ds);
  assign w_e    = PROD_W'(w);
  assign ov_e   = PROD_W'(ov);
  assign vds_e  = PROD_W'(v_ds);

  always_comb begin
    prod = '0;
    if (is_tri) begin
      prod = eff_id ? w_e * ((ov_e << 1) * vds_e - vds_e * vds_e)
                    : (w_e * vds_e) << 1;
    end else if (!is_cut) begin
      prod = eff_id ? w_e * ov_e * ov_e
                    : (w_e * ov_e) << 1;
    end
  end

  assign new_val = VAL_W'(prod / PROD_W'(3));

  // ---------------- insertion sort ----------------
  // The first sample of a burst sorts against a zeroed array. This is the
  // same as clearing the array on entry to LOAD.
  // ge[] is a run of ones followed by zeros. The new value lands at the
  // first zero, so it goes after any equal entries.
  logic [VAL_W-1:0] base    [N_DEV];
  logic [VAL_W-1:0] ins_val [N_DEV];
  logic [N_DEV-1:0] ge;

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_ins
    assign base[gi] = first ? '0 : d_reg[gi];
    assign ge[gi]   = (base[gi] >= new_val);
    if (gi == 0) begin : g_head
      assign ins_val[gi] = ge[gi] ? base[gi] : new_val;
    end else begin : g_body
      assign ins_val[gi] = ge[gi]     ? base[gi]
                         : ge[gi-1]   ? new_val
                         :              base[gi-1];
    end
  end

  // ---------------- selection and weighted sum ----------------
  logic [SUM_W-1:0] term [K_SEL];
  logic [SUM_W-1:0] acc;
  logic [OUT_W-1:0] calc_result;

  for (genvar gi = 0; gi < K_SEL; gi++) begin : g_sel
    logic [VAL_W-1:0] a_sel;
    assign a_sel    = mode_reg[1] ? d_reg[gi] : d_reg[N_DEV-K_SEL+gi];
    assign term[gi] = mode_reg[0] ? SUM_W'(K_SEL + gi) * SUM_W'(a_sel)
                                  : SUM_W'(a_sel);
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < K_SEL; i++) begin
      acc = acc + term[i];
    end
  end

  assign calc_result = OUT_W'(mode_reg[0] ? acc / SUM_W'(D_ID)
                                          : acc / SUM_W'(K_SEL));

`ifdef SMC_REGION_CNT_EN
  logic             is_sat;
  logic [CNT_W-1:0] sat_acc_reg;
  assign is_sat = !is_cut && !is_tri;
`endif

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      mode_reg   <= '0;
      result_reg <= '0;
      for (int i = 0; i < N_DEV; i++) d_reg[i] <= '0;
`ifdef SMC_REGION_CNT_EN
      sat_acc_reg <= '0;
`endif
    end else begin
      if (accept) begin
        for (int i = 0; i < N_DEV; i++) d_reg[i] <= ins_val[i];
        if (first) mode_reg <= mode;
        cnt_reg <= last_sample ? '0 : cnt_reg + 1'b1;
`ifdef SMC_REGION_CNT_EN
        sat_acc_reg <= first ? CNT_W'(is_sat) : sat_acc_reg + CNT_W'(is_sat);
`endif
      end else if (state_reg == S_LOAD) begin
        cnt_reg <= '0;  // burst broken off, so it is discarded
      end
      if (state_reg == S_CALC) result_reg <= calc_result;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (in_valid) state_next = (N_DEV == 1) ? S_CALC : S_LOAD;
      S_LOAD: begin
        if (!in_valid)        state_next = S_IDLE;
        else if (last_sample) state_next = S_CALC;
      end
      S_CALC: state_next = S_OUT;
      S_OUT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_next = 1'b0;
    out_n_next     = '0;
    if (state_reg == S_OUT) begin
      out_valid_next = 1'b1;
      out_n_next     = result_reg;
    end
  end

  // Outputs are registered, so the strobe follows the OUT state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_n     <= '0;
`ifdef SMC_REGION_CNT_EN
      sat_cnt   <= '0;
`endif
    end else begin
      out_valid <= out_valid_next;
      out_n     <= out_n_next;
`ifdef SMC_REGION_CNT_EN
      sat_cnt   <= (state_reg == S_OUT) ? sat_acc_reg : '0;
`endif
    end
  end

endmodule

// File: tb/tb_smc_stream_eval.sv
// Scoreboard bench for smc_stream_eval.
// The stimulus process queues the expected result and its arrival cycle.
// A negedge monitor pops and compares each strobe, and checks idle outputs.
module tb_smc_stream_eval;
  localparam int N_DEV = 6;
  localparam int K_SEL = 3;
  localparam int CNT_W = $clog2(N_DEV + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] w = 3'd0, v_gs = 3'd0, v_ds = 3'd0;
  logic       out_valid;
  logic [9:0] out_n;
`ifdef SMC_REGION_CNT_EN
  logic [CNT_W-1:0] sat_cnt;
`endif

  smc_stream_eval #(.N_DEV(N_DEV), .IN_W(3), .K_SEL(K_SEL), .OUT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .w(w), .v_gs(v_gs), .v_ds(v_ds),
    .out_valid(out_valid), .out_n(out_n)
`ifdef SMC_REGION_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  typedef struct {
    int     val;
    int     sat;
    longint at;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int dw[N_DEV], dg[N_DEV], dd[N_DEV];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          mon_e = q.pop_front();
          txn++;
          $display("TXN %0d cycle=%0d out_n=%0d expected=%0d", txn, cyc, out_n, mon_e.val);
          check("out_n", out_n, mon_e.val);
          check("latency", cyc, mon_e.at);
`ifdef SMC_REGION_CNT_EN
          check("sat_cnt", sat_cnt, mon_e.sat);
`endif
        end
      end else begin
        check("idle_out_n", out_n, 0);
`ifdef SMC_REGION_CNT_EN
        check("idle_sat_cnt", sat_cnt, 0);
`endif
      end
    end
  end

  // Drive one burst from dw/dg/dd. Later samples carry an inverted mode,
  // because mode must only be taken from the first sample.
  task automatic burst(input logic [1:0] m, input int ev, input int es, input bit expect_out);
    for (int i = 0; i < N_DEV; i++) begin
      in_valid = 1'b1;
      mode = (i == 0) ? m : ~m;
      w = 3'(dw[i]); v_gs = 3'(dg[i]); v_ds = 3'(dd[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (expect_out) q.push_back('{ev, es, cyc + 2});
  endtask

  // The two cycles of CALC and OUT. With junk set, in_valid stays high and
  // carries garbage, which must be ignored.
  task automatic gap(input bit junk);
    for (int i = 0; i < 2; i++) begin
      in_valid = junk;
      mode = 2'($urandom_range(0, 3));
      w = 3'($urandom_range(0, 7)); v_gs = 3'($urandom_range(0, 7)); v_ds = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic set_all(input int a, input int b, input int c);
    for (int i = 0; i < N_DEV; i++) begin dw[i] = a; dg[i] = b; dd[i] = c; end
  endtask

  task automatic set_mixed();
    dw = '{7, 1, 3, 2, 7, 1};
    dg = '{7, 3, 4, 3, 7, 1};
    dd = '{7, 1, 7, 1, 2, 5};
  endtask

  // Reference model: evaluate each device, bubble sort descending, then combine.
  task automatic model(input logic [1:0] m, output int val, output int sat);
    int v[N_DEV];
    int ov, t, acc, a;
    sat = 0;
    for (int i = 0; i < N_DEV; i++) begin
      ov = dg[i] - 1;
      if (dg[i] <= 1) v[i] = 0;
      else if (ov > dd[i]) v[i] = m[0] ? dw[i] * (2 * ov * dd[i] - dd[i] * dd[i]) / 3
                                       : 2 * dw[i] * dd[i] / 3;
      else begin
        sat++;
        v[i] = m[0] ? dw[i] * ov * ov / 3 : 2 * dw[i] * ov / 3;
      end
    end
    for (int i = 0; i < N_DEV; i++)
      for (int j = 0; j < N_DEV - 1 - i; j++)
        if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    acc = 0;
    for (int i = 0; i < K_SEL; i++) begin
      a = m[1] ? v[i] : v[N_DEV - K_SEL + i];
      acc += m[0] ? (K_SEL + i) * a : a;
    end
    val = (m[0] ? acc / 12 : acc / K_SEL) & 1023;
  endtask

  initial begin
    int ev, es;
    logic [1:0] m;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_n", out_n, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All (7,7,7): Id largest = 84
    set_all(7, 7, 7);
    burst(2'd3, 84, 6, 1'b1);
    gap(1'b0);

    // Mixed burst sorts to 84,46,9,2,1,0
    set_mixed();
    burst(2'd3, 40, 2, 1'b1);
    gap(1'b0);
    burst(2'd1, 0, 2, 1'b1);
    gap(1'b0);

    // gm largest of (7,7,7) = 28
    set_all(7, 7, 7);
    burst(2'd2, 28, 6, 1'b1);
    gap(1'b0);

    // Burst broken off after 4 samples: no result
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; mode = 2'd3; w = 3'd7; v_gs = 3'd7; v_ds = 3'd7;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    burst(2'd3, 84, 6, 1'b1);
    gap(1'b0);

    // Reset pulsed during CALC aborts the burst
    set_mixed();
    burst(2'd3, 0, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_n", out_n, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    set_all(7, 7, 7);
    burst(2'd3, 84, 6, 1'b1);
    gap(1'b0);

    // Back-to-back random bursts, in_valid held high through CALC and OUT
    for (int b = 0; b < 2000; b++) begin
      m = 2'($urandom_range(0, 3));
      for (int i = 0; i < N_DEV; i++) begin
        dw[i] = $urandom_range(0, 7);
        dg[i] = $urandom_range(0, 7);
        dd[i] = $urandom_range(0, 7);
      end
      model(m, ev, es);
      burst(m, ev, es, 1'b1);
      gap(1'b1);
    end
    in_valid = 1'b0;

    // Drain the scoreboard, with a bounded wait
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
